// File: rtl/otter_pc_sequencer.sv
// OTTER multicycle PC/control sequencer: INIT/FETCH/EXEC/WB/INTR.
// Drives pc_sel/pc_write, memory and regfile strobes, and trap pulses.
//
// Ports:
//   CLK, RST       clock, async active-high reset
//   is_load..      decoded instruction class flags
//   br_taken       branch condition (EXEC)
//   rf_we_dec      decoder register-write request
//   mem_we_dec     decoder store request
//   intr, mie      interrupt request and enable
//   pc_sel         next-PC select code
//   pc_write       PC load enable
//   mem_rden1/2    imem / dmem read enables
//   mem_we2        dmem write enable
//   reg_write      regfile write enable
//   int_taken      interrupt-entry pulse
//   mret_exec      MRET pulse
//   state_dbg      current state encoding
module otter_pc_sequencer #(
  parameter int unsigned INIT_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       is_load,
  input  logic       is_jal,
  input  logic       is_jalr,
  input  logic       is_branch,
  input  logic       br_taken,
  input  logic       is_mret,
  input  logic       rf_we_dec,
  input  logic       mem_we_dec,
  input  logic       intr,
  input  logic       mie,
  output logic [2:0] pc_sel,
  output logic       pc_write,
  output logic       mem_rden1,
  output logic       mem_rden2,
  output logic       mem_we2,
  output logic       reg_write,
  output logic       int_taken,
  output logic       mret_exec,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_WB    = 3'd3;
  localparam logic [2:0] ST_INTR  = 3'd4;

  localparam logic [2:0] SEL_PC4  = 3'b000;
  localparam logic [2:0] SEL_JALR = 3'b001;
  localparam logic [2:0] SEL_BR   = 3'b010;
  localparam logic [2:0] SEL_JAL  = 3'b011;
  localparam logic [2:0] SEL_MTVEC = 3'b100;
  localparam logic [2:0] SEL_MEPC = 3'b101;

  localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;

  logic       irq_go;
  logic [2:0] jump_sel;

  // Trap request seen at an instruction boundary.
  assign irq_go = (pend_q | intr) & mie;

  // Non-load control-transfer select, MRET first.
  always_comb begin
    jump_sel = SEL_PC4;
    if (is_mret)
      jump_sel = SEL_MEPC;
    else if (is_jal)
      jump_sel = SEL_JAL;
    else if (is_jalr)
      jump_sel = SEL_JALR;
    else if (is_branch && br_taken)
      jump_sel = SEL_BR;
  end

  // Pending latch: a new request wins over the clear when leaving INTR,
  // and mie has no effect on holding it.
  always_comb begin
    pend_d = pend_q;
    if (state_q == ST_INTR)
      pend_d = 1'b0;
    if (intr)
      pend_d = 1'b1;
  end

  always_comb begin
    state_d   = ST_INIT;
    cnt_d     = cnt_q;
    pc_sel    = SEL_PC4;
    pc_write  = 1'b0;
    mem_rden1 = 1'b0;
    mem_rden2 = 1'b0;
    mem_we2   = 1'b0;
    reg_write = 1'b0;
    int_taken = 1'b0;
    mret_exec = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == INIT_LAST) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_INIT;
          cnt_d   = cnt_q + 4'd1;
        end
      end
      ST_FETCH: begin
        mem_rden1 = 1'b1;
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_load) begin
          mem_rden2 = 1'b1;
          state_d   = ST_WB;
        end else begin
          pc_write  = 1'b1;
          reg_write = rf_we_dec;
          mem_we2   = mem_we_dec;
          pc_sel    = jump_sel;
          mret_exec = is_mret;
          // MRET returns to the interrupted stream for one instruction.
          if (irq_go && !is_mret)
            state_d = ST_INTR;
          else
            state_d = ST_FETCH;
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        state_d   = irq_go ? ST_INTR : ST_FETCH;
      end
      ST_INTR: begin
        pc_write  = 1'b1;
        pc_sel    = SEL_MTVEC;
        int_taken = 1'b1;
        state_d   = ST_FETCH;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_INIT;
      cnt_q   <= 4'd0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: doc/otter_pc_sequencer.md
Name: otter_pc_sequencer

Overview:
Multicycle control sequencer for the OTTER core's program-counter path. It steps each instruction through the INIT/FETCH/EXEC/WB/INTR states and drives the 3-bit next-PC select code and the PC write enable. It also strobes the instruction/data memory reads, the register-file write and the data-memory write. It owns the pending-interrupt latch and issues interrupt-entry and MRET pulses to the CSR block.

Parameters:
INIT_CYCLES, 1, number of cycles held in INIT after reset deassertion (memory warm-up); legal range 1..15.

Ports:
CLK  input  1  system clock, all state on rising edge
RST  input  1  asynchronous, active-high reset
is_load  input  1  decoded instruction is a load
is_jal  input  1  decoded JAL
is_jalr  input  1  decoded JALR
is_branch  input  1  decoded conditional branch
br_taken  input  1  branch condition true (valid in EXEC)
is_mret  input  1  decoded MRET
rf_we_dec  input  1  decoder requests register write
mem_we_dec  input  1  decoder requests data-memory write (store)
intr  input  1  external interrupt request, single-cycle pulse or level
mie  input  1  machine interrupt enable from CSR
pc_sel  output  3  next-PC select: 000 PC+4, 001 JALR, 010 branch, 011 JAL, 100 mtvec, 101 mepc
pc_write  output  1  PC register load enable
mem_rden1  output  1  instruction-memory read enable
mem_rden2  output  1  data-memory read enable
mem_we2  output  1  data-memory write enable
reg_write  output  1  register-file write enable
int_taken  output  1  one-cycle pulse: interrupt entry (CSR saves mepc, clears mie)
mret_exec  output  1  one-cycle pulse: MRET executing (CSR restores mie)
state_dbg  output  3  current state: INIT=0, FETCH=1, EXEC=2, WB=3, INTR=4

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (RST); all flops clear immediately on RST assertion.
- Reset values:
  - state = INIT, init counter = 0, pend = 0.
  - All enables and pulses 0; pc_sel = 000.
  - Reset mid-instruction aborts with no further writes.
- Outputs are a Moore/Mealy mix decoded combinationally from the state and the decode inputs. Outputs not listed for a state are 0, and pc_sel = 000.
- INIT: counter increments each cycle. When counter = INIT_CYCLES-1, next state = FETCH, and the counter holds.
- FETCH: mem_rden1 = 1. Next state = EXEC, unconditionally.
- EXEC, when is_load = 1:
  - mem_rden2 = 1, pc_write = 0. Next state = WB.
- EXEC, when is_load = 0:
  - pc_write = 1, reg_write = rf_we_dec, mem_we2 = mem_we_dec.
  - pc_sel priority: is_mret → 101 (mret_exec = 1); is_jal → 011; is_jalr → 001; is_branch & br_taken → 010; else 000.
  - An untaken branch selects 000.
  - Next state = INTR if (pend | intr) & mie & ~is_mret, else FETCH.
  - MRET never goes straight to INTR. A pending interrupt is taken after the next instruction's EXEC.
- WB: reg_write = 1, pc_write = 1, pc_sel = 000. Next state = INTR if (pend | intr) & mie, else FETCH.
- INTR: pc_write = 1, pc_sel = 100, int_taken = 1. Next state = FETCH.
- Pending latch (pend):
  - Sets on any cycle with intr = 1. Clears on the clock edge leaving INTR.
  - If intr = 1 during INTR, set wins and pend stays 1.
  - When mie = 0, pend is held, not dropped. It is taken at the first EXEC/WB decision point after mie returns to 1.
- Exactly one of {pc_write in EXEC, pc_write in WB, pc_write in INTR} occurs per instruction/trap.
- pc_write is never 1 in INIT or FETCH.
- Multiple decode flags asserted at once resolve by the priority above. No error is raised.
- Illegal state encodings (5–7) fall to INIT on the next edge.
- Instruction latency:
  - Non-load: 2 cycles (FETCH, EXEC).
  - Load: 3 cycles.
  - Interrupt entry: 1 extra cycle.

Test Plan:
- Reset/INIT: INIT_CYCLES = 3. Hold RST 2 cycles, release → state_dbg = 0 for 3 cycles, then 1. All outputs are 0 during INIT.
- ALU op, then taken branch: rf_we_dec = 1 → EXEC gives pc_write = 1, pc_sel = 000, reg_write = 1. Next instruction with is_branch = br_taken = 1 → pc_sel = 010, reg_write = 0. Untaken branch → pc_sel = 000.
- Load/store:
  - is_load = 1 → EXEC shows mem_rden2 = 1, pc_write = 0. WB shows reg_write = 1, pc_write = 1, pc_sel = 000. The FETCH→FETCH period is 3 cycles.
  - Store → mem_we2 = 1 in EXEC only.
- Interrupt:
  - mie = 1, intr pulse during FETCH → after EXEC, INTR with pc_sel = 100, int_taken = 1 for exactly 1 cycle, then FETCH; pend = 0.
  - Second intr pulse during INTR → taken again after the next EXEC.
- Masked/MRET:
  - mie = 0, intr pulse → no INTR. Raise mie 4 instructions later → INTR follows the next EXEC.
  - is_mret with pend = 1 → pc_sel = 101, mret_exec = 1, next state FETCH, not INTR.
- Priority/robustness:
  - is_jal = is_jalr = 1 together → pc_sel = 011.
  - Assert RST in the WB cycle → reg_write/pc_write drop immediately; state = INIT.
